// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shift-mode encodings shared by the barrel shifter top and its per-level stages.
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } sh_mode_e;

  // Bit position whose value is the last bit shifted out, for a nonzero amount.
  // LSL loses bits from the top; every other mode loses them from the bottom.
  function automatic int unsigned carry_pos(input sh_mode_e mode, input int unsigned amt,
                                            input int unsigned width);
    return (mode == SH_LSL) ? (width - amt) % width : (amt + width - 1) % width;
  endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_level.sv
// One log-shifter level: conditional fixed-distance shift, pipeline register and
// valid/ready load control. Mode, amount and carry ride along with the data.
module shifter_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHIFT = 1,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       in_mode,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_mode,
  output logic [AMT_W-1:0] out_amt,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry
);

  localparam int BIT = $clog2(SHIFT);

  logic             ld;
  logic [WIDTH-1:0] shifted;

  // Load when empty or when the downstream stage takes our current content.
  assign ld = !out_valid || out_ready;

  always_comb begin
    shifted = in_data;
    if (in_amt[BIT]) begin
      case (sh_mode_e'(in_mode))
        SH_LSL:  shifted = in_data << SHIFT;
        SH_LSR:  shifted = in_data >> SHIFT;
        SH_ASR:  shifted = WIDTH'($signed(in_data) >>> SHIFT);
        SH_ROR:  shifted = (in_data >> SHIFT) | (in_data << (WIDTH - SHIFT));
        default: shifted = in_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_mode  <= '0;
      out_amt   <= '0;
      out_data  <= '0;
      out_carry <= 1'b0;
    end else if (ld) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_mode  <= in_mode;
        out_amt   <= in_amt;
        out_data  <= shifted;
        out_carry <= in_carry;
      end
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined log-depth barrel shifter (LSL/LSR/ASR/ROR) with valid/ready flow
// control, carry-out and zero flags. One level per shift-amount bit, MSB first.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [1:0]       SH_MODE,
  input  logic [AMT_W-1:0] SH_AMT,
  input  logic [WIDTH-1:0] D_IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] D_OUT,
  output logic             D_CARRY,
  output logic             D_ZERO
);

  // Index 0 is the input port side; index k+1 is the register of level k.
  logic [AMT_W:0]            vld_pipe;
  logic [AMT_W:0]            rdy_pipe;
  logic [AMT_W:0]            cy_pipe;
  logic [AMT_W:0][1:0]       mode_pipe;
  logic [AMT_W:0][AMT_W-1:0] amt_pipe;
  logic [AMT_W:0][WIDTH-1:0] data_pipe;
  logic [AMT_W-1:0]          cy_idx;
  logic                      carry0;
  logic                      unused_ctrl;

  // Carry is fully determined by the original operand, so resolve it up front.
  always_comb begin
    cy_idx = AMT_W'(carry_pos(sh_mode_e'(SH_MODE), int'(SH_AMT), WIDTH));
    carry0 = (SH_AMT == '0) ? 1'b0 : D_IN[cy_idx];
  end

  assign vld_pipe[0]  = IN_VALID;
  assign mode_pipe[0] = SH_MODE;
  assign amt_pipe[0]  = SH_AMT;
  assign data_pipe[0] = D_IN;
  assign cy_pipe[0]   = carry0;

  // Ready ripples back from the output: a level may load if the next one is empty
  // or itself loading. Written as one loop so the chain is a plain combinational path.
  always_comb begin
    rdy_pipe[AMT_W] = OUT_READY;
    for (int k = AMT_W - 1; k >= 0; k--)
      rdy_pipe[k] = !vld_pipe[k+1] || rdy_pipe[k+1];
  end

  for (genvar k = 0; k < AMT_W; k++) begin : g_lvl
    shifter_level #(
      .WIDTH (WIDTH),
      .SHIFT (1 << (AMT_W - 1 - k)),
      .AMT_W (AMT_W)
    ) u_lvl (
      .clk       (CLK),
      .rst       (RST),
      .in_valid  (vld_pipe[k]),
      .in_mode   (mode_pipe[k]),
      .in_amt    (amt_pipe[k]),
      .in_data   (data_pipe[k]),
      .in_carry  (cy_pipe[k]),
      .out_valid (vld_pipe[k+1]),
      .out_ready (rdy_pipe[k+1]),
      .out_mode  (mode_pipe[k+1]),
      .out_amt   (amt_pipe[k+1]),
      .out_data  (data_pipe[k+1]),
      .out_carry (cy_pipe[k+1])
    );
  end

  // Input is refused while reset is held so nothing slips in during the flush.
  assign IN_READY  = rdy_pipe[0] && !RST;
  assign OUT_VALID = vld_pipe[AMT_W];
  assign D_OUT     = data_pipe[AMT_W];
  assign D_CARRY   = cy_pipe[AMT_W];
  assign D_ZERO    = vld_pipe[AMT_W] && (data_pipe[AMT_W] == '0);

  // Mode/amount are dead after the last level.
  assign unused_ctrl = ^{mode_pipe[AMT_W], amt_pipe[AMT_W]};

endmodule
